mem_bus_interconnect: RTL and testbench

Parametrised successor to the single-cycle memory controller. Decodes a CPU data-bus request against N_SLAVES address regions and translates the address to a word offset. Runs a request/ready handshake with variable-latency slaves, with timeout, misalignment and unmapped-address error reporting. Sits between the core's load/store path and the ROM/RAM/GPIO slaves for the multi-cycle datapath.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_region_decoder.sv | 38 +++
 rtl/mem_bus_interconnect.sv | 146 ++++++++++++++
 tb/tb_mem_bus_interconnect.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and the default address map for the data-bus interconnect.
// Regions are {base, mask}; an address hits when (addr & mask) == base.
package mem_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] mask;
    } MEM_REGION_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } BUS_STATE_t;

    localparam int DEFAULT_N = 4;

    localparam MEM_REGION_t REGION_GPIO_OUT = '{base: 32'h1001_0024, mask: 32'hFFFF_FFFF};
    localparam MEM_REGION_t REGION_GPIO_IN  = '{base: 32'h1001_0028, mask: 32'hFFFF_FFFF};
    localparam MEM_REGION_t REGION_RAM      = '{base: 32'h1001_0000, mask: 32'hFFFF_0000};
    localparam MEM_REGION_t REGION_ROM      = '{base: 32'h0040_0000, mask: 32'hFFC0_0000};

    // Concatenation is MSB-first, so index 0 (highest priority) is the last element.
    localparam MEM_REGION_t [DEFAULT_N-1:0] DEFAULT_MAP =
        {REGION_ROM, REGION_RAM, REGION_GPIO_IN, REGION_GPIO_OUT};

endpackage

// File: rtl/mem_region_decoder.sv
// Combinational address decoder: priority region match, alignment check and
// translation of the byte address into a word offset within the hit region.
module mem_region_decoder
    import mem_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
    parameter MEM_REGION_t [N_SLAVES-1:0] REGION_MAP = DEFAULT_MAP
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic              misaligned,
    output logic [ADDR_W-1:0] offset
);

    logic [ADDR_W-1:0] base_sel;

    // NOTE: every output gets a default before the loop; a path that leaves one
    // unassigned would make synthesis infer a latch.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Scanning downwards lets the lowest matching index overwrite the others.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & REGION_MAP[i].mask[ADDR_W-1:0]) == REGION_MAP[i].base[ADDR_W-1:0]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
        base_sel = REGION_MAP[idx].base[ADDR_W-1:0];
        offset   = (addr - base_sel) >> 2;
    end

    assign misaligned = |addr[1:0];

endmodule

// File: rtl/mem_bus_interconnect.sv
// Data-bus interconnect: decodes a CPU request, runs a request/ready handshake
// with the selected variable-latency slave and returns a one-cycle response.
module mem_bus_interconnect
    import mem_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 15,
    parameter MEM_REGION_t [N_SLAVES-1:0] REGION_MAP = DEFAULT_MAP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bus_req,
    input  logic [ADDR_W-1:0]            bus_addr,
    input  logic [DATA_W-1:0]            bus_wrdata,
    input  logic                         bus_wren,
    output logic                         bus_ready,
    output logic [DATA_W-1:0]            bus_rddata,
    output logic                         bus_err,
    output logic [N_SLAVES-1:0]          slv_sel,
    output logic [ADDR_W-1:0]            slv_addr,
    output logic [DATA_W-1:0]            slv_wrdata,
    output logic [N_SLAVES-1:0]          slv_wren,
    input  logic [N_SLAVES-1:0]          slv_ready,
    input  logic [N_SLAVES*DATA_W-1:0]   slv_rddata
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter starts at 0 in the first ACCESS cycle, so this value marks the last allowed one.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    BUS_STATE_t        state, state_next;
    logic              dec_hit, dec_misaligned, req_ok;
    logic [IDX_W-1:0]  dec_idx;
    logic [ADDR_W-1:0] dec_offset;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q, rddata_q;
    logic              wren_q, err_q;
    logic [IDX_W-1:0]  idx_q;

    logic              sel_ready, timed_out;
    logic [DATA_W-1:0] sel_rddata;

    mem_region_decoder #(
        .N_SLAVES   (N_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .REGION_MAP (REGION_MAP)
    ) u_decoder (
        .addr       (bus_addr),
        .hit        (dec_hit),
        .idx        (dec_idx),
        .misaligned (dec_misaligned),
        .offset     (dec_offset)
    );

    assign req_ok     = dec_hit && !dec_misaligned;
    assign sel_ready  = slv_ready[idx_q];
    assign sel_rddata = slv_rddata[idx_q*DATA_W +: DATA_W];
    assign timed_out  = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: the request registers are plain flops, not a memory, so they are all
    // reset; an abandoned access leaves nothing behind to be replayed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            idx_q    <= '0;
            rddata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_req) begin
                        if (req_ok) begin
                            addr_q   <= dec_offset;
                            wrdata_q <= bus_wrdata;
                            wren_q   <= bus_wren;
                            idx_q    <= dec_idx;
                            cnt      <= '0;
                        end
                        err_q    <= !req_ok;
                        rddata_q <= '0;
                    end
                end
                ACCESS: begin
                    // A ready in the final allowed cycle still counts as success.
                    if (sel_ready) begin
                        rddata_q <= wren_q ? '0 : sel_rddata;
                        err_q    <= 1'b0;
                    end else if (timed_out) begin
                        rddata_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        bus_ready  = 1'b0;
        bus_err    = 1'b0;
        bus_rddata = '0;
        slv_sel    = '0;
        slv_wren   = '0;
        slv_addr   = '0;
        slv_wrdata = '0;
        case (state)
            IDLE: begin
                if (bus_req) state_next = req_ok ? ACCESS : RESP;
            end
            ACCESS: begin
                slv_sel[idx_q]  = 1'b1;
                slv_wren[idx_q] = wren_q;
                slv_addr        = addr_q;
                slv_wrdata      = wrdata_q;
                if (sel_ready || timed_out) state_next = RESP;
            end
            RESP: begin
                bus_ready  = 1'b1;
                bus_err    = err_q;
                bus_rddata = rddata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Self-checking bench for mem_bus_interconnect: directed vector table, reset
// corner cases and random transactions against an address-map reference model.
module tb_mem_bus_interconnect;

    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         rst;
    logic         bus_req;
    logic [31:0]  bus_addr, bus_wrdata;
    logic         bus_wren;
    logic         bus_ready, bus_err;
    logic [31:0]  bus_rddata;
    logic [3:0]   slv_sel, slv_wren, slv_ready;
    logic [31:0]  slv_addr, slv_wrdata;
    logic [127:0] slv_rddata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_bus_interconnect dut (
        .clk        (clk),
        .rst        (rst),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wrdata (bus_wrdata),
        .bus_wren   (bus_wren),
        .bus_ready  (bus_ready),
        .bus_rddata (bus_rddata),
        .bus_err    (bus_err),
        .slv_sel    (slv_sel),
        .slv_addr   (slv_addr),
        .slv_wrdata (slv_wrdata),
        .slv_wren   (slv_wren),
        .slv_ready  (slv_ready),
        .slv_rddata (slv_rddata)
    );

    typedef struct packed {
        logic        ready;
        logic        err;
        logic [31:0] rd;
        logic [3:0]  sel;
        logic [3:0]  wren;
        logic [31:0] addr;
        logic [31:0] wrdata;
    } obs_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wren;
        int          wait_cyc;
        logic [31:0] sdata;
        logic [3:0]  sel;
        logic [31:0] off;
        logic        err;
        int          lat;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[12];

    // Independent copy of the documented address map, index 0 first.
    logic [31:0] map_base[4] = '{32'h1001_0024, 32'h1001_0028, 32'h1001_0000, 32'h0040_0000};
    logic [31:0] map_mask[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFC0_0000};

    function automatic obs_t observe();
        obs_t o;
        o.ready  = bus_ready;
        o.err    = bus_err;
        o.rd     = bus_rddata;
        o.sel    = slv_sel;
        o.wren   = slv_wren;
        o.addr   = slv_addr;
        o.wrdata = slv_wrdata;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got ready=%0b err=%0b rddata=%h sel=%b wren=%b addr=%h wrdata=%h; want ready=%0b err=%0b rddata=%h sel=%b wren=%b addr=%h wrdata=%h",
                     name, act.ready, act.err, act.rd, act.sel, act.wren, act.addr, act.wrdata,
                     exp.ready, exp.err, exp.rd, exp.sel, exp.wren, exp.addr, exp.wrdata);
        else
            n_pass++;
    endtask

    // Expected outcome of one request, from the map and the handshake rules.
    task automatic model(input logic [31:0] addr, input logic wren, input int wait_cyc,
                         input logic [31:0] sdata, output logic [3:0] sel, output logic [31:0] off,
                         output logic err, output int lat, output logic [31:0] rd);
        int k = -1;
        for (int i = 3; i >= 0; i--)
            if ((addr & map_mask[i]) == map_base[i]) k = i;
        sel = '0; off = '0; rd = '0;
        if (k < 0 || addr[1:0] != 2'b00) begin
            err = 1'b1;
            lat = 1;
        end else begin
            sel = 4'(1 << k);
            off = (addr - map_base[k]) / 4;
            if (wait_cyc < TIMEOUT) begin
                err = 1'b0;
                lat = 2 + wait_cyc;
                rd  = wren ? 32'h0 : sdata;
            end else begin
                err = 1'b1;
                lat = 1 + TIMEOUT;
            end
        end
    endtask

    // Starts #1 after a rising edge with the DUT idle; ends the same way.
    // The selected slave raises ready in ACCESS cycle wait_cyc+1.
    task automatic run_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic wren, input int wait_cyc, input logic [31:0] sdata,
                           input logic [3:0] e_sel, input logic [31:0] e_off, input logic e_err,
                           input int e_lat, input logic [31:0] e_rd, input bit noise);
        obs_t e;
        int   c = 0;
        bit   done = 0;
        bus_req    = 1'b1;
        bus_addr   = addr;
        bus_wrdata = wdata;
        bus_wren   = wren;
        slv_rddata = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++)
            if (e_sel[i]) slv_rddata[i*32 +: 32] = sdata;
        while (!done) begin
            slv_ready = noise ? (4'($urandom) & ~e_sel) : 4'h0;
            if (wait_cyc == 0 || c > wait_cyc) slv_ready = slv_ready | e_sel;
            if (noise && c > 0) begin
                bus_addr   = $urandom;
                bus_wrdata = $urandom;
                bus_wren   = 1'($urandom);
            end
            @(negedge clk);
            e = '0;
            if (c == e_lat) begin
                e.ready = 1'b1;
                e.err   = e_err;
                e.rd    = e_rd;
            end else if (c > 0 && c < e_lat && e_sel != 4'h0) begin
                e.sel    = e_sel;
                e.wren   = wren ? e_sel : 4'h0;
                e.addr   = e_off;
                e.wrdata = wdata;
            end
            if (c <= e_lat) check($sformatf("%s cyc%0d", name, c), observe(), e);
            if (bus_ready) bus_req = 1'b0;
            if ((bus_ready && c >= e_lat) || c > e_lat + 30) done = 1;
            @(posedge clk);
            #1;
            c++;
        end
        bus_req   = 1'b0;
        slv_ready = '0;
    endtask

    initial begin
        obs_t        e;
        logic [31:0] a, wd, sd, off, rd;
        logic        wr, err;
        logic [3:0]  sel;
        int          w, lat, kind;

        rst = 1'b0; bus_req = 1'b0; bus_addr = '0; bus_wrdata = '0; bus_wren = 1'b0;
        slv_ready = '0; slv_rddata = '0;

        //            addr          wdata         wr  wait sdata         sel      off            err  lat rd
        vecs[0]  = '{32'h0040_0010, 32'h0,        0,  0,  32'hDEAD_BEEF, 4'b1000, 32'h4,         0,   2,  32'hDEAD_BEEF};
        vecs[1]  = '{32'h1001_0008, 32'h1234_5678, 1, 2,  32'hCAFE_0000, 4'b0100, 32'h2,         0,   4,  32'h0};
        vecs[2]  = '{32'h1001_0024, 32'h0000_00FF, 1, 0,  32'h1111_1111, 4'b0001, 32'h0,         0,   2,  32'h0};
        vecs[3]  = '{32'h1001_0028, 32'h0,        0,  1,  32'hA5A5_0001, 4'b0010, 32'h0,         0,   3,  32'hA5A5_0001};
        vecs[4]  = '{32'h2000_0000, 32'h0,        0,  0,  32'h7777_7777, 4'b0000, 32'h0,         1,   1,  32'h0};
        vecs[5]  = '{32'h1001_0002, 32'h0,        0,  0,  32'h7777_7777, 4'b0000, 32'h0,         1,   1,  32'h0};
        vecs[6]  = '{32'h1001_0100, 32'h0,        0,  99, 32'h5555_5555, 4'b0100, 32'h40,        1,   16, 32'h0};
        vecs[7]  = '{32'h1001_0004, 32'h0,        0,  14, 32'h600D_F00D, 4'b0100, 32'h1,         0,   16, 32'h600D_F00D};
        vecs[8]  = '{32'h007F_FFFC, 32'h0,        0,  0,  32'h0BAD_F00D, 4'b1000, 32'h000F_FFFF, 0,   2,  32'h0BAD_F00D};
        vecs[9]  = '{32'h1001_FFFC, 32'hFFFF_FFFF, 1, 3,  32'h0,         4'b0100, 32'h3FFF,      0,   5,  32'h0};
        vecs[10] = '{32'h0040_0001, 32'h0,        1,  0,  32'h0,         4'b0000, 32'h0,         1,   1,  32'h0};
        vecs[11] = '{32'h1001_002C, 32'h0,        0,  0,  32'h2C2C_2C2C, 4'b0100, 32'hB,         0,   2,  32'h2C2C_2C2C};

        // A valid request presented during reset must not start anything.
        repeat (2) @(posedge clk);
        #1;
        bus_req = 1'b1; bus_addr = 32'h0040_0010; slv_ready = '1;
        repeat (2) begin
            @(negedge clk);
            check("reset_state", observe(), '0);
        end
        bus_req = 1'b0; slv_ready = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wren,
                    vecs[i].wait_cyc, vecs[i].sdata, vecs[i].sel, vecs[i].off, vecs[i].err,
                    vecs[i].lat, vecs[i].rd, 1'b0);

        // Reset in the second ACCESS cycle of a RAM write.
        bus_req = 1'b1; bus_addr = 32'h1001_0008; bus_wrdata = 32'h1234_5678; bus_wren = 1'b1;
        slv_ready = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        e = '0; e.sel = 4'b0100; e.wren = 4'b0100; e.addr = 32'h2; e.wrdata = 32'h1234_5678;
        check("rst_pre_access", observe(), e);
        #1 rst = 1'b0;
        #1 check("rst_async_clear", observe(), '0);
        bus_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_hold_no_ready", observe(), '0);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_idle", observe(), '0);
        end
        @(posedge clk);
        #1;
        run_txn("post_rst_read", 32'h0040_0020, 32'h0, 1'b0, 0, 32'h1357_9BDF,
                4'b1000, 32'h8, 1'b0, 2, 32'h1357_9BDF, 1'b0);

        // Random traffic with noise on non-selected readies and scrambled bus inputs.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0:       a = 32'h0040_0000 | ($urandom & 32'h003F_FFFC);
                1:       a = 32'h1001_0000 | ($urandom & 32'h0000_FFFC);
                2:       a = 32'h1001_0024;
                3:       a = 32'h1001_0028;
                4:       a = $urandom;
                default: a = 32'h1001_0000 | ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
            endcase
            wd = $urandom;
            sd = $urandom;
            wr = 1'($urandom);
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
            model(a, wr, w, sd, sel, off, err, lat, rd);
            run_txn($sformatf("rand%0d", n), a, wd, wr, w, sd, sel, off, err, lat, rd, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
